// File: rtl/udp_tx_sched_if.sv
// udp_tx_sched_if: requester handshakes and the framed UDP word stream of udp_tx_sched.
// Carries a state_dbg field so monitors can follow the scheduler FSM.
interface udp_tx_sched_if;
  // Requester i raises req_i with len_i stable and holds it until gnt_i rises.
  // While rd_i is high, data_i is consumed at every clock edge where valid_i is high;
  // valid_i low while rd_i is high truncates the packet.
  logic        req_0, req_1;
  logic [13:0] len_0, len_1;
  logic        gnt_0, gnt_1;
  logic [31:0] data_0, data_1;
  logic        valid_0, valid_1;
  logic        rd_0, rd_1;
  logic [31:0] udp_data_out;
  logic        udp_data_valid;
  logic        pkt_done;
  logic        underrun_err;
  logic [2:0]  state_dbg;

  modport slave (
    input  req_0, req_1, len_0, len_1, data_0, data_1, valid_0, valid_1,
    output gnt_0, gnt_1, rd_0, rd_1, udp_data_out, udp_data_valid,
           pkt_done, underrun_err, state_dbg
  );

  modport master (
    output req_0, req_1, len_0, len_1, data_0, data_1, valid_0, valid_1,
    input  gnt_0, gnt_1, rd_0, rd_1, udp_data_out, udp_data_valid,
           pkt_done, underrun_err, state_dbg
  );
endinterface

// File: rtl/udp_tx_sched.sv
// udp_tx_sched: round-robin scheduler framing two requesters' payloads as UDP datagrams.
// Define UDP_TX_IFG_EN to stretch the inter-packet GAP state to IFG cycles (default: 1 cycle).
module udp_tx_sched #(
  parameter logic [15:0] SRC_PORT = 16'h0400,
  parameter logic [15:0] DES_PORT = 16'h00aa,
  parameter int unsigned IFG      = 4
) (
  input logic           clk,
  input logic           reset_n,
  udp_tx_sched_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR0 = 3'd1,
    HDR1 = 3'd2,
    DATA = 3'd3,
    GAP  = 3'd4
  } state_t;

`ifdef UDP_TX_IFG_EN
  localparam logic [3:0] GAP_LAST = 4'(IFG - 1);
`else
  // Single-cycle gap; IFG is only meaningful in the gapped build.
  localparam logic [3:0] GAP_LAST = 4'(IFG - IFG);
`endif

  state_t      state, state_nxt;
  logic        owner;           // requester granted most recently (current owner while busy)
  logic [13:0] cnt;             // payload words still to send
  logic [3:0]  gap_cnt;
  logic        any_req, pick, busy;
  logic        sel_valid;
  logic [31:0] sel_data;
  logic [15:0] udp_len;
  logic [31:0] out_nxt;
  logic        vld_nxt, done_set, under_set, done_pend;

  assign any_req   = bus.req_0 | bus.req_1;
  assign pick      = (bus.req_0 & bus.req_1) ? ~owner : bus.req_1;
  assign sel_valid = owner ? bus.valid_1 : bus.valid_0;
  assign sel_data  = owner ? bus.data_1  : bus.data_0;
  assign udp_len   = {cnt, 2'b00} + 16'd8;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_req) state_nxt = HDR0;
      HDR0: state_nxt = HDR1;
      HDR1: state_nxt = (cnt == 14'd0) ? GAP : DATA;
      DATA: if (!sel_valid || cnt == 14'd1) state_nxt = GAP;
      GAP:  if (gap_cnt == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: ownership strobes plus the values captured by the output register
  always_comb begin
    out_nxt   = '0;
    vld_nxt   = 1'b0;
    done_set  = 1'b0;
    under_set = 1'b0;
    case (state)
      HDR0: begin
        out_nxt = {SRC_PORT, DES_PORT};
        vld_nxt = 1'b1;
      end
      HDR1: begin
        out_nxt  = {udp_len, 16'h0000};
        vld_nxt  = 1'b1;
        done_set = (cnt == 14'd0);
      end
      DATA: begin
        if (sel_valid) begin
          out_nxt  = sel_data;
          vld_nxt  = 1'b1;
          done_set = (cnt == 14'd1);
        end else begin
          under_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy          = (state == HDR0) || (state == HDR1) || (state == DATA);
  assign bus.gnt_0     = busy & ~owner;
  assign bus.gnt_1     = busy &  owner;
  assign bus.rd_0      = (state == DATA) & ~owner;
  assign bus.rd_1      = (state == DATA) &  owner;
  assign bus.state_dbg = state;

  // Datapath: grant latch, word counter, gap timer and the registered stream.
  // pkt_done trails the final valid word by one cycle via done_pend.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner              <= 1'b1;
      cnt                <= '0;
      gap_cnt            <= '0;
      bus.udp_data_out   <= '0;
      bus.udp_data_valid <= 1'b0;
      bus.underrun_err   <= 1'b0;
      bus.pkt_done       <= 1'b0;
      done_pend          <= 1'b0;
    end else begin
      if (state == IDLE && any_req) begin
        owner <= pick;
        cnt   <= pick ? bus.len_1 : bus.len_0;
      end else if (state == DATA && sel_valid) begin
        cnt <= cnt - 14'd1;
      end
      if (state != GAP && state_nxt == GAP)   gap_cnt <= GAP_LAST;
      else if (state == GAP && gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
      bus.udp_data_out   <= out_nxt;
      bus.udp_data_valid <= vld_nxt;
      bus.underrun_err   <= under_set;
      done_pend          <= done_set;
      bus.pkt_done       <= done_pend;
    end
  end

endmodule

// File: tb/tb_udp_tx_sched.sv
// tb_udp_tx_sched: table-driven packet vectors, reset/round-robin sequences and random
// traffic, with every output word checked against an expected-word queue.
module tb_udp_tx_sched;

  localparam logic [31:0] HDR0_W = 32'h0400_00aa;
`ifdef UDP_TX_IFG_EN
  localparam int GAP_CYC = 4;
`else
  localparam int GAP_CYC = 1;
`endif

  typedef struct {
    bit          who;
    logic [13:0] len;
    int          drop;       // data word index at which valid is withheld, -1 for none
    logic [31:0] base;
    bit          exp_done;
    bit          exp_under;
    int          exp_words;  // valid words expected on the stream
  } vec_t;

  logic clk, reset_n;
  udp_tx_sched_if bus();

  udp_tx_sched dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  int          runs_q[$];
  int          gaps_q[$];
  bit          gl_q[$];
  int          done_cnt = 0, under_cnt = 0, rd0_cnt = 0, rd1_cnt = 0;
  logic [31:0] base0, base1;
  int          drop0, drop1;

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Requester sources: present base+idx while granted, advance after each consumed word
  initial begin : src
    int idx0, idx1;
    bit p0, p1;
    idx0 = 0; idx1 = 0; p0 = 0; p1 = 0;
    bus.valid_0 = 1'b0; bus.valid_1 = 1'b0;
    bus.data_0 = '0; bus.data_1 = '0;
    forever begin
      @(negedge clk);
      if (!bus.gnt_0) idx0 = 0; else if (p0) idx0++;
      if (!bus.gnt_1) idx1 = 0; else if (p1) idx1++;
      bus.valid_0 = bus.gnt_0 && (idx0 != drop0);
      bus.valid_1 = bus.gnt_1 && (idx1 != drop1);
      bus.data_0  = base0 + 32'(idx0);
      bus.data_1  = base1 + 32'(idx1);
      p0 = bus.rd_0 && bus.valid_0;
      p1 = bus.rd_1 && bus.valid_1;
    end
  end

  // Monitor: scoreboard pops, pulse alignment, run/gap lengths, grant order
  initial begin : mon
    bit pv, pg0, pg1, seen_fall;
    int run, lo;
    logic [31:0] e;
    pv = 0; pg0 = 0; pg1 = 0; seen_fall = 0; run = 0; lo = 0;
    forever begin
      @(negedge clk);
      if (bus.udp_data_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stray_word: got %h with no word expected", bus.udp_data_out);
        end else begin
          e = exp_q.pop_front();
          check("word", bus.udp_data_out, e);
        end
        if (!pv) begin
          if (seen_fall) gaps_q.push_back(lo);
          run = 0;
        end
        run++;
      end else begin
        if (pv) begin
          runs_q.push_back(run);
          seen_fall = 1;
          lo = 0;
        end
        lo++;
      end
      if (bus.pkt_done) begin
        done_cnt++;
        check("done_align", {30'd0, pv, bus.udp_data_valid}, 32'd2);
      end
      if (bus.underrun_err) begin
        under_cnt++;
        check("underrun_align", {30'd0, pv, bus.udp_data_valid}, 32'd2);
      end
      if (bus.rd_0) rd0_cnt++;
      if (bus.rd_1) rd1_cnt++;
      if (bus.gnt_0 && !pg0) gl_q.push_back(1'b0);
      if (bus.gnt_1 && !pg1) gl_q.push_back(1'b1);
      pv  = bus.udp_data_valid;
      pg0 = bus.gnt_0;
      pg1 = bus.gnt_1;
    end
  end

  task automatic push_packet(input logic [13:0] len, input int n, input logic [31:0] base);
    logic [15:0] f;
    f = {len, 2'b00} + 16'd8;
    exp_q.push_back(HDR0_W);
    exp_q.push_back({f, 16'h0000});
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(i));
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (bus.state_dbg != 3'd0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("reach_idle", 32'(bus.state_dbg), 32'd0);
  endtask

  // One packet from an idle scheduler, with latency, pulse and count checks
  task automatic run_packet(input vec_t v);
    int d0, u0, r0, n, c;
    n  = (v.drop >= 0 && v.drop < int'(v.len)) ? v.drop : int'(v.len);
    d0 = done_cnt;
    u0 = under_cnt;
    r0 = v.who ? rd1_cnt : rd0_cnt;
    @(negedge clk);
    push_packet(v.len, n, v.base);
    if (v.who) begin
      base1 = v.base; drop1 = v.drop; bus.len_1 = v.len; bus.req_1 = 1'b1;
    end else begin
      base0 = v.base; drop0 = v.drop; bus.len_0 = v.len; bus.req_0 = 1'b1;
    end
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(v.who ? bus.gnt_1 : bus.gnt_0) && c < 20);
    check("grant_latency", 32'(c), 32'd1);
    check("pre_hdr_valid", 32'(bus.udp_data_valid), 32'd0);
    // Release the request and scramble len: neither may disturb the packet in flight
    bus.req_0 = 1'b0;
    bus.req_1 = 1'b0;
    bus.len_0 = 14'($urandom);
    bus.len_1 = 14'($urandom);
    @(negedge clk);
    check("hdr0_latency", 32'(bus.udp_data_valid), 32'd1);
    wait_idle(int'(v.len) + 40);
    repeat (3) @(negedge clk);
    check("pkt_done_count", 32'(done_cnt - d0), 32'(v.exp_done));
    check("underrun_count", 32'(under_cnt - u0), 32'(v.exp_under));
    check("rd_cycles", 32'((v.who ? rd1_cnt : rd0_cnt) - r0), 32'(n + int'(v.exp_under)));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("run_length", (runs_q.size() > 0) ? 32'(runs_q[runs_q.size()-1]) : 32'hffff_ffff,
          32'(v.exp_words));
  endtask

  initial begin : main
    vec_t vecs[7];
    vec_t rv;
    int d0, u0, c;

    vecs[0] = '{1'b0, 14'd3,  -1, 32'h0000_0000, 1'b1, 1'b0, 5};
    vecs[1] = '{1'b1, 14'd0,  -1, 32'h0000_0100, 1'b1, 1'b0, 2};
    vecs[2] = '{1'b0, 14'd4,   2, 32'h0000_0200, 1'b0, 1'b1, 4};
    vecs[3] = '{1'b1, 14'd5,  -1, 32'ha000_0000, 1'b1, 1'b0, 7};
    vecs[4] = '{1'b0, 14'd1,  -1, 32'h0000_0055, 1'b1, 1'b0, 3};
    vecs[5] = '{1'b1, 14'd3,   0, 32'h0000_0300, 1'b0, 1'b1, 2};
    vecs[6] = '{1'b0, 14'd64, -1, 32'hdead_0000, 1'b1, 1'b0, 66};

    reset_n = 1'b0;
    bus.req_0 = 1'b0; bus.req_1 = 1'b0;
    bus.len_0 = '0;   bus.len_1 = '0;
    base0 = '0; base1 = '0; drop0 = -1; drop1 = -1;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(bus.udp_data_valid), 32'd0);
    check("rst_out", bus.udp_data_out, 32'd0);
    check("rst_gnt", {30'd0, bus.gnt_1, bus.gnt_0}, 32'd0);
    check("rst_rd", {30'd0, bus.rd_1, bus.rd_0}, 32'd0);
    check("rst_pulses", {30'd0, bus.pkt_done, bus.underrun_err}, 32'd0);
    check("rst_state", 32'(bus.state_dbg), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_packet(vecs[i]);

    // Reset in the middle of a payload
    @(negedge clk);
    base0 = 32'h0000_0700; drop0 = -1; bus.len_0 = 14'd8; bus.req_0 = 1'b1;
    push_packet(14'd8, 8, 32'h0000_0700);
    c = 0;
    while (!bus.gnt_0 && c < 20) begin @(negedge clk); c++; end
    bus.req_0 = 1'b0;
    c = 0;
    while (bus.state_dbg != 3'd3 && c < 20) begin @(negedge clk); c++; end
    check("reach_data", 32'(bus.state_dbg), 32'd3);
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    u0 = under_cnt;
    reset_n = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.udp_data_valid), 32'd0);
    check("midrst_out", bus.udp_data_out, 32'd0);
    check("midrst_gnt_rd", {30'd0, bus.gnt_0, bus.rd_0}, 32'd0);
    check("midrst_state", 32'(bus.state_dbg), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_pulses", 32'((done_cnt - d0) + (under_cnt - u0)), 32'd0);

    // Both requests held: round robin from requester 0, fixed gap between packets
    runs_q.delete(); gaps_q.delete(); gl_q.delete();
    @(negedge clk);
    base0 = 32'h0000_1000; base1 = 32'h0000_2000; drop0 = -1; drop1 = -1;
    bus.len_0 = 14'd2; bus.len_1 = 14'd2;
    bus.req_0 = 1'b1;  bus.req_1 = 1'b1;
    for (int k = 0; k < 4; k++) push_packet(14'd2, 2, (k % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
    c = 0;
    while (gl_q.size() < 4 && c < 200) begin @(negedge clk); c++; end
    bus.req_0 = 1'b0;
    bus.req_1 = 1'b0;
    wait_idle(100);
    repeat (3) @(negedge clk);
    check("rr_grants", 32'(gl_q.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      check("rr_order", (k < gl_q.size()) ? 32'(gl_q[k]) : 32'hffff_ffff, 32'(k % 2));
    for (int k = 0; k < 4; k++)
      check("rr_run", (k < runs_q.size()) ? 32'(runs_q[k]) : 32'hffff_ffff, 32'd4);
    for (int k = 1; k < 4; k++)
      check("rr_gap", (k < gaps_q.size()) ? 32'(gaps_q[k]) : 32'hffff_ffff, 32'(GAP_CYC + 1));
    check("rr_drained", 32'(exp_q.size()), 32'd0);

    // Random-length traffic through the scoreboard
    for (int p = 0; p < 100; p++) begin
      rv.who       = 1'($urandom_range(0, 1));
      rv.len       = 14'($urandom_range(1, 64));
      rv.drop      = -1;
      rv.base      = $urandom;
      rv.exp_done  = 1'b1;
      rv.exp_under = 1'b0;
      rv.exp_words = int'(rv.len) + 2;
      run_packet(rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
